// File: rtl/led_indicator_bank_if.sv
// led_indicator_bank_if: request/mode/clear inputs and LED/active/tick outputs of the indicator bank.
interface led_indicator_bank_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] req;
  logic blink_en;
  logic turnoff;
  logic [N_CH-1:0] led;
  logic [N_CH-1:0] active;
  logic tick;
  modport master (output req, blink_en, turnoff, input led, active, tick);
  modport slave (input req, blink_en, turnoff, output led, active, tick);
endinterface

// File: rtl/led_indicator_bank.sv
// led_indicator_bank: N-channel steady/blink LED driver with per-channel hold timeout,
// global turnoff and a free-running prescaler producing the slow tick.
module led_indicator_bank #(
  parameter int N_CH = 4,
  parameter int CLK_DIV = 40_000_000,
  parameter int HOLD_TICKS = 8
) (
  input logic clkin,
  input logic reset,
  led_indicator_bank_if.slave bus
);
  localparam int PW = $clog2(CLK_DIV);
  localparam int HW = HOLD_TICKS > 0 ? $clog2(HOLD_TICKS + 1) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST = HW'(HOLD_TICKS > 0 ? HOLD_TICKS - 1 : 0);
  localparam logic [1:0] OFF = 2'd0;
  localparam logic [1:0] ON = 2'd1;
  localparam logic [1:0] BLINK = 2'd2;
  logic [PW-1:0] pre;
  logic tick_q;
  logic [N_CH-1:0] req_prev;
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      pre <= '0;
      tick_q <= 1'b0;
      req_prev <= '0;
    end else begin
      pre <= pre == P_LAST ? '0 : pre + 1'b1;
      tick_q <= pre == P_LAST;
      req_prev <= bus.req;
    end
  end
  assign bus.tick = tick_q;
  for (genvar g = 0; g < N_CH; g++) begin : ch
    logic [1:0] st, st_n;
    logic ph, ph_n;
    logic [HW-1:0] cnt, cnt_n;
    logic rise, expire, led_q, act_q;
    assign rise = bus.req[g] & ~req_prev[g];
    assign expire = HOLD_TICKS != 0 && cnt == H_LAST;
    // turnoff beats a rise, and a rise beats a tick in the same cycle
    always_comb begin
      st_n = st;
      ph_n = ph;
      cnt_n = cnt;
      if (bus.turnoff) begin
        st_n = OFF;
        ph_n = 1'b0;
        cnt_n = '0;
      end else if (rise) begin
        st_n = bus.blink_en ? BLINK : ON;
        ph_n = 1'b1;
        cnt_n = '0;
      end else if (tick_q && st != OFF) begin
        st_n = expire ? OFF : st;
        ph_n = expire ? 1'b0 : (st == BLINK ? ~ph : ph);
        cnt_n = expire ? '0 : (HOLD_TICKS != 0 ? cnt + 1'b1 : cnt);
      end
    end
    always_ff @(posedge clkin or posedge reset) begin
      if (reset) begin
        st <= OFF;
        ph <= 1'b0;
        cnt <= '0;
        led_q <= 1'b0;
        act_q <= 1'b0;
      end else begin
        st <= st_n;
        ph <= ph_n;
        cnt <= cnt_n;
        led_q <= st_n == ON || (st_n == BLINK && ph_n);
        act_q <= st_n != OFF;
      end
    end
    assign bus.led[g] = led_q;
    assign bus.active[g] = act_q;
  end
endmodule

// File: tb/tb_led_indicator_bank.sv
// tb_led_indicator_bank: scoreboard bench driving a HOLD_TICKS=3 and a HOLD_TICKS=0 instance
// with identical stimulus; expectations come from a ticks-since-trigger model.
module tb_led_indicator_bank;
  localparam int N = 4;
  localparam int CD = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  led_indicator_bank_if #(.N_CH(N)) ba ();
  led_indicator_bank_if #(.N_CH(N)) bb ();
  led_indicator_bank #(.N_CH(N), .CLK_DIV(CD), .HOLD_TICKS(3)) dut_a (.clkin(clk), .reset(reset), .bus(ba));
  led_indicator_bank #(.N_CH(N), .CLK_DIV(CD), .HOLD_TICKS(0)) dut_b (.clkin(clk), .reset(reset), .bus(bb));
  int checks = 0;
  int failures = 0;
  logic [8:0] qa[$];
  logic [8:0] qb[$];
  bit running = 1'b0;
  int n;
  logic [N-1:0] prev;
  bit on_m[2][N];
  bit bl_m[2][N];
  int el_m[2][N];
  int hold[2] = '{3, 0};
  task automatic cmp(input string nm, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got led/active/tick=%b required=%b", nm, $time, got, exp);
    end
  endtask
  task automatic model_reset();
    n = 0;
    prev = '0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < N; i++) begin
        on_m[d][i] = 1'b0;
        bl_m[d][i] = 1'b0;
        el_m[d][i] = 0;
      end
  endtask
  task automatic drive(input logic [N-1:0] r, input logic be, input logic to);
    bit tk;
    logic [N-1:0] led, act;
    ba.req = r; bb.req = r;
    ba.blink_en = be; bb.blink_en = be;
    ba.turnoff = to; bb.turnoff = to;
    tk = n > 0 && n % CD == 0;
    n++;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < N; i++) begin
        if (to) begin
          on_m[d][i] = 1'b0;
          el_m[d][i] = 0;
        end else if (r[i] && !prev[i]) begin
          on_m[d][i] = 1'b1;
          bl_m[d][i] = be;
          el_m[d][i] = 0;
        end else if (on_m[d][i] && tk) begin
          el_m[d][i]++;
          if (hold[d] != 0 && el_m[d][i] >= hold[d]) on_m[d][i] = 1'b0;
        end
        led[i] = on_m[d][i] && (!bl_m[d][i] || el_m[d][i] % 2 == 0);
        act[i] = on_m[d][i];
      end
      if (d == 0) qa.push_back({led, act, n % CD == 0});
      else qb.push_back({led, act, n % CD == 0});
    end
    prev = r;
  endtask
  task automatic step(input logic [N-1:0] r, input logic be, input logic to);
    @(negedge clk);
    drive(r, be, to);
  endtask
  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(prev, 1'b0, 1'b0);
  endtask
  task automatic check_cleared(input string nm);
    cmp({nm, "_a"}, {ba.led, ba.active, ba.tick}, 9'b0);
    cmp({nm, "_b"}, {bb.led, bb.active, bb.tick}, 9'b0);
  endtask
  initial forever begin
    @(posedge clk);
    #2;
    if (running) begin
      if (qa.size() == 0 || qb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty t=%0t queued a=%0d b=%0d required>=1", $time, qa.size(), qb.size());
      end else begin
        cmp("dut_a", {ba.led, ba.active, ba.tick}, qa.pop_front());
        cmp("dut_b", {bb.led, bb.active, bb.tick}, qb.pop_front());
      end
    end
  end
  initial begin
    logic [N-1:0] cur;
    ba.req = '0; bb.req = '0;
    ba.blink_en = 1'b0; bb.blink_en = 1'b0;
    ba.turnoff = 1'b0; bb.turnoff = 1'b0;
    repeat (3) @(negedge clk);
    check_cleared("power_on_reset");
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    running = 1'b1;
    drive('0, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    idle(16);
    step(4'b0100, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    idle(16);
    step(4'b0010, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    idle(8);
    step(4'b0010, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    idle(5);
    step(4'b0010, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    idle(16);
    for (int k = 0; k < 8; k++) begin
      step(4'b1010, k[0], 1'b0);
      step(4'b0000, 1'b0, 1'b0);
      idle(k + 1);
    end
    idle(16);
    step(4'b1001, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(4'b0010, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    idle(100 * CD + 4);
    step(4'b0000, 1'b0, 1'b1);
    idle(4);
    cur = '0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) if ($urandom % 8 == 0) cur[i] = ~cur[i];
      step(cur, 1'($urandom % 2), $urandom % 40 == 0);
    end
    step(4'b0110, 1'b1, 1'b0);
    step(4'b1111, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    running = 1'b0;
    reset = 1'b1;
    ba.req = 4'b1111; bb.req = 4'b1111;
    #1;
    check_cleared("mid_cycle_reset");
    repeat (2) @(negedge clk);
    check_cleared("held_reset");
    ba.req = '0; bb.req = '0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    running = 1'b1;
    drive('0, 1'b0, 1'b0);
    step(4'b1111, 1'b0, 1'b0);
    idle(6);
    step(4'b0000, 1'b0, 1'b0);
    idle(20);
    @(posedge clk);
    #3;
    running = 1'b0;
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain leftover a=%0d b=%0d required=0", qa.size(), qb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
